// File: rtl/hadamard_stream_ctrl.sv
//==============================================================================
// hadamard_stream_ctrl: valid/ready launch, in-flight tagging and credit-backed
// result FIFO around a free-running fixed-latency hadamard. Rev 1.0. Option: HSC_PERF_CNT_EN
//==============================================================================
`default_nettype none

module hadamard_stream_ctrl #(
   parameter int EXP_WIDTH    = 4,
   parameter int SIG_WIDTH    = 4,
   parameter int FORMAT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH,
   parameter int HD_LATENCY   = 5,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic                      s_last,
   input  logic [4*FORMAT_WIDTH-1:0] s_real,
   input  logic [4*FORMAT_WIDTH-1:0] s_imag,
   input  logic [4*FORMAT_WIDTH-1:0] s_tw_real,
   input  logic [4*FORMAT_WIDTH-1:0] s_tw_imag,
   output logic                      hd_start,
   output logic [4*FORMAT_WIDTH-1:0] hd_in_real,
   output logic [4*FORMAT_WIDTH-1:0] hd_in_imag,
   output logic [4*FORMAT_WIDTH-1:0] hd_tw_real,
   output logic [4*FORMAT_WIDTH-1:0] hd_tw_imag,
   input  logic [4*FORMAT_WIDTH-1:0] hd_out_real,
   input  logic [4*FORMAT_WIDTH-1:0] hd_out_imag,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [4*FORMAT_WIDTH-1:0] m_real,
   output logic [4*FORMAT_WIDTH-1:0] m_imag,
`ifdef HSC_PERF_CNT_EN
   output logic [15:0]               perf_blocks,
   output logic [15:0]               perf_stall,
`endif
   output logic                      m_last
);

   localparam int BUS_W = 4 * FORMAT_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = 2 * BUS_W + 1;
   localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(FIFO_DEPTH);

   logic                  w_accept;
   logic                  w_pop;
   logic                  w_wr_en;
   logic                  w_empty;
   logic                  w_full;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_used;
   logic [PTR_W-1:0]      w_used_next;
   logic [HD_LATENCY:0]   r_vld_pipe;
   logic [HD_LATENCY:0]   r_last_pipe;
   logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
   logic [ENT_W-1:0]      w_head;

   assign w_accept = s_valid & s_ready;
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);
   assign m_valid  = !w_empty;
   assign w_pop    = m_valid & m_ready;
   assign w_wr_en  = r_vld_pipe[HD_LATENCY] & (!w_full | w_pop);

   // Credits cover both in-flight blocks and buffered results, so every launch has a slot.
   always_comb begin
      w_used_next = r_used;
      case ({w_accept, w_pop})
         2'b10:   w_used_next = r_used + 1'b1;
         2'b01:   w_used_next = r_used - 1'b1;
         default: w_used_next = r_used;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_used  <= '0;
         s_ready <= 1'b0;
      end else begin
         r_used  <= w_used_next;
         s_ready <= (w_used_next < DEPTH_CNT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hd_start   <= 1'b0;
         hd_in_real <= '0;
         hd_in_imag <= '0;
         hd_tw_real <= '0;
         hd_tw_imag <= '0;
      end else begin
         hd_start <= w_accept;
         if (w_accept) begin
            hd_in_real <= s_real;
            hd_in_imag <= s_imag;
            hd_tw_real <= s_tw_real;
            hd_tw_imag <= s_tw_imag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else begin
         r_vld_pipe  <= {r_vld_pipe[HD_LATENCY-1:0], w_accept};
         r_last_pipe <= {r_last_pipe[HD_LATENCY-1:0], w_accept & s_last};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_wr_ptr[PTR_W-2:0]] <= {hd_out_real, hd_out_imag, r_last_pipe[HD_LATENCY]};
   end

   // Head is masked while empty so stale storage never shows on m_*.
   assign w_head = r_mem[r_rd_ptr[PTR_W-2:0]];
   assign m_real = w_empty ? '0   : w_head[ENT_W-1 -: BUS_W];
   assign m_imag = w_empty ? '0   : w_head[BUS_W   -: BUS_W];
   assign m_last = w_empty ? 1'b0 : w_head[0];

`ifdef HSC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_blocks <= '0;
         perf_stall  <= '0;
      end else begin
         if (w_accept && (perf_blocks != 16'hFFFF))
            perf_blocks <= perf_blocks + 16'd1;
         if (s_valid && !s_ready && (perf_stall != 16'hFFFF))
            perf_stall <= perf_stall + 16'd1;
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

`default_nettype wire
